hub_mem_initiator: RTL and testbench
====================================

# hub_mem_initiator

Round-robin hub access initiator that drives the hub memory bus on behalf of COGS requesters (cogs). It rotates a slot pointer on every bus-enable cycle, issues at most one byte/word/long access per slot to the hub memory, and handles byte-lane selection. It returns lane-aligned, zero-extended read data with a one-cycle ack. It sits between the cog array and the hub memory, on the initiator side of the memory's w/wb/a/d/q interface.

## Interface
- COGS, 8, number of requesters; legal range 4..16.
- SW, 4, slot pointer width; must be at least clog2(COGS).
- clk_cog  in  1  cog clock; all state on rising edge.
- res  in  1  asynchronous, active-high reset.
- ena_bus  in  1  bus enable strobe; slot advances and issue happens only when high.
- req  in  COGS  per-cog request; held high until ack.
- req_w  in  COGS  1 = write, 0 = read.
- req_sz  in  2*COGS  size code: 00 byte, 01 word, 10 long, 11 treated as long.
- req_adr  in  16*COGS  byte address per cog.
- req_d  in  32*COGS  write data, right-justified.
- ack  out  COGS  one-cycle pulse to the owning cog; reset 0.
- rd_q  out  32  aligned read data, valid while ack is high; reset 0.
- slot  out  SW  current slot pointer; reset 0.
- mem_ena  out  1  memory enable, high for exactly one cycle per issue; reset 0.
- mem_w  out  1  write strobe; reset 0.
- mem_wb  out  4  byte-lane write enables; reset 0.
- mem_a  out  14  long address; equals adr[15:2]; reset 0.
- mem_d  out  32  lane-replicated write data; reset 0.
- mem_q  in  32  memory read data, valid one cycle after the memory samples.

## Operation
- Slot counter: +1 on each clk_cog edge where ena_bus=1; wraps from COGS-1 to 0.
- Issue condition at edge T0: ena_bus=1 AND req[slot]=1 AND pending[slot]=0. Effects: register mem_* outputs, set pending[slot], latch owner, size, and adr[1:0].
- An idle slot is wasted. Slots are never borrowed.
- Write lanes, byte: wb = 1<<adr[1:0], d = {4{d[7:0]}}.
- Write lanes, word: wb = adr[1] ? 1100 : 0011, d = {2{d[15:0]}}. adr[0] is ignored.
- Write lanes, long: wb = 1111. adr[1:0] are ignored.
- Read-back: byte returns mem_q lane adr[1:0], zero-extended. Word returns the half selected by adr[1], zero-extended. Long returns mem_q as-is.
- Writes also ack. rd_q then carries the pre-write contents, because the memory is read-before-write.
- pending[i] clears on the edge after ack[i] falls. The cog must drop req in the cycle it sees ack; a held req is re-issued at its next slot.
- Reset: asynchronous. All outputs and pending go to 0 and slot goes to 0. In-flight accesses are dropped with no ack.

## Timing
- T0: request sampled. mem_* are valid during the cycle after T0, and mem_ena falls after one cycle.
- T1: memory samples. mem_q is valid after T1.
- T2: rd_q and ack[owner] are registered. ack is high during the cycle after T2.
- Latency from the sampling edge to ack-visible is 3 edges, independent of ena_bus duty.
- Pipeline overlap: up to two accesses are in flight, one per stage, from different slots. COGS>=4 guarantees that a slot never re-issues before its own ack.
- Reset asserted between T0 and T2 cancels the access. mem_ena and ack fall immediately.

## Configuration
- HUB_ROM_WP_EN defined: a write with adr[15]=1 is issued with mem_w=0 and mem_wb=0000. It completes as a read, with normal ack and rd_q.
- HUB_ROM_WP_EN undefined: the write is passed through unchanged, and the memory ignores ROM writes itself.

## Structure
- Package hub_pkg holds the SZ_BYTE, SZ_WORD, and SZ_LONG codes, the HUB_AW=14 and HUB_DW=32 constants, and the default COGS.
- Sub-module hub_lane_align is purely combinational. On the write side it maps size/adr[1:0]/d to wb/replicated d; on the read side it maps size/adr[1:0]/q to aligned rd_q. It is instantiated once for write and once for read.

## Test plan
- COGS=8, ena_bus=1 constantly, cog 3 writes long 0x12345678 to byte address 0x0010 -> mem_ena pulse with a=0x0004 and wb=1111. ack[3] arrives 3 edges later. A read of 0x0010 then returns 0x12345678.
- Byte write 0xAB to 0x0013, then byte read of 0x0013 -> wb=1000, mem_d=0xABABABAB, rd_q=0x000000AB.
- Word read at 0x0012 of long 0xABCD5678 -> rd_q=0x0000ABCD. Word read at 0x0011 returns 0x00005678 (adr[0] ignored).
- All 8 cogs request simultaneously with ena_bus toggling every other cycle -> acks arrive in slot order 0..7, one every 2 cycles, with no duplicates.
- Reset asserted one cycle after issue -> no ack, mem_ena=0 immediately, slot=0. A re-issued request then completes normally.
- Write to 0x8000: with HUB_ROM_WP_EN, mem_w=0 and rd_q is the ROM word. Without it, mem_w=1 and wb=1111.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for the hub memory initiator: access size codes,
// hub bus geometry and the default requester count.
package hub_pkg;

  // Size code carried with every request; 2'b11 is handled as a long.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_WORD     = 2'b01,
    SZ_LONG     = 2'b10,
    SZ_LONG_ALT = 2'b11
  } hub_sz_e;

  // Hub memory is addressed in longs: 14 address bits, 32 data bits.
  localparam int HUB_AW = 14;
  localparam int HUB_DW = 32;

  // Default number of cogs that share the hub.
  localparam int COGS_DEFAULT = 8;

endpackage

// File: rtl/hub_lane_align.sv
// Combinational byte-lane steering for hub accesses.
// Write side: size and adr[1:0] select the lane enables, and the write data
// is replicated across the long. Read side: the addressed lane or half of the
// memory long is moved to bit 0 and zero-extended.
module hub_lane_align
  import hub_pkg::*;
(
  input  logic [1:0]        sz,
  input  logic [1:0]        lo,
  input  logic [HUB_DW-1:0] d,
  input  logic [HUB_DW-1:0] q,
  output logic [3:0]        wb,
  output logic [HUB_DW-1:0] d_rep,
  output logic [HUB_DW-1:0] rd
);

  // Lane selection, write replication and read alignment by access size.
  always_comb begin
    wb    = 4'b0000;
    d_rep = '0;
    rd    = '0;
    case (hub_sz_e'(sz))
      SZ_BYTE: begin
        wb    = 4'b0001 << lo;
        d_rep = {4{d[7:0]}};
        case (lo)
          2'd0:    rd = {24'h000000, q[7:0]};
          2'd1:    rd = {24'h000000, q[15:8]};
          2'd2:    rd = {24'h000000, q[23:16]};
          default: rd = {24'h000000, q[31:24]};
        endcase
      end
      SZ_WORD: begin
        // Words are always half-long aligned; adr[0] plays no part.
        wb    = lo[1] ? 4'b1100 : 4'b0011;
        d_rep = {2{d[15:0]}};
        rd    = lo[1] ? {16'h0000, q[31:16]} : {16'h0000, q[15:0]};
      end
      default: begin
        // Long and the spare code: full long, adr[1:0] ignored.
        wb    = 4'b1111;
        d_rep = d;
        rd    = q;
      end
    endcase
  end

endmodule

// File: rtl/hub_mem_initiator.sv
// Round-robin hub access initiator.
// A slot pointer steps on every ena_bus cycle; the cog owning the current slot
// may start one byte/word/long access, which is presented to the hub memory
// for a single cycle. Read data (pre-write contents for writes) comes back
// lane-aligned with a one-cycle ack three edges after the request was taken.
// Pipeline: issue (_p1, drives mem_*) -> memory sample (_p2) -> response.
// Optional build macro HUB_ROM_WP_EN: writes to adr[15]=1 are demoted to
// reads so the ROM half of the hub can never be written.
module hub_mem_initiator
  import hub_pkg::*;
#(
  parameter int COGS = COGS_DEFAULT,
  parameter int SW   = 4
) (
  input  logic                clk_cog,
  input  logic                res,
  input  logic                ena_bus,
  input  logic [COGS-1:0]     req,
  input  logic [COGS-1:0]     req_w,
  input  logic [2*COGS-1:0]   req_sz,
  input  logic [16*COGS-1:0]  req_adr,
  input  logic [32*COGS-1:0]  req_d,
  output logic [COGS-1:0]     ack,
  output logic [HUB_DW-1:0]   rd_q,
  output logic [SW-1:0]       slot,
  output logic                mem_ena,
  output logic                mem_w,
  output logic [3:0]          mem_wb,
  output logic [HUB_AW-1:0]   mem_a,
  output logic [HUB_DW-1:0]   mem_d,
  input  logic [HUB_DW-1:0]   mem_q
);

  logic [COGS-1:0]   pending;

  // Fields of the cog that owns the current slot.
  logic              sel_req;
  logic              sel_w;
  logic              sel_pend;
  logic [1:0]        sel_sz;
  logic [15:0]       sel_adr;
  logic [31:0]       sel_d;

  logic              issue;
  logic              wr_eff;
  logic [3:0]        wr_wb;
  logic [HUB_DW-1:0] wr_d;
  logic [HUB_DW-1:0] rd_al;

  // Sides of the shared lane-steering block that a given instance does not need.
  logic [HUB_DW-1:0] unused_wr_rd;
  logic [3:0]        unused_rd_wb;
  logic [HUB_DW-1:0] unused_rd_d;

  // Pipeline bookkeeping: who owns the access and how to align the result.
  logic              vld_p1;
  logic              vld_p2;
  logic [SW-1:0]     owner_p1;
  logic [SW-1:0]     owner_p2;
  logic [1:0]        sz_p1;
  logic [1:0]        sz_p2;
  logic [1:0]        lo_p1;
  logic [1:0]        lo_p2;
  logic [COGS-1:0]   ack_nxt;

  // Pick the request fields of the cog addressed by the slot pointer.
  always_comb begin
    sel_req  = 1'b0;
    sel_w    = 1'b0;
    sel_pend = 1'b0;
    sel_sz   = 2'b00;
    sel_adr  = 16'h0000;
    sel_d    = 32'h00000000;
    for (int i = 0; i < COGS; i++) begin
      if (slot == SW'(i)) begin
        sel_req  = req[i];
        sel_w    = req_w[i];
        sel_pend = pending[i];
        sel_sz   = req_sz[2*i +: 2];
        sel_adr  = req_adr[16*i +: 16];
        sel_d    = req_d[32*i +: 32];
      end
    end
  end

  // An idle or already-busy slot is simply wasted; no other cog borrows it.
  assign issue = ena_bus & sel_req & ~sel_pend;

`ifdef HUB_ROM_WP_EN
  // Writes into the ROM half degrade to plain reads.
  assign wr_eff = sel_w & ~sel_adr[15];
`else
  // The memory itself ignores ROM writes; pass them straight through.
  assign wr_eff = sel_w;
`endif

  hub_lane_align u_wr_align (
    .sz    (sel_sz),
    .lo    (sel_adr[1:0]),
    .d     (sel_d),
    .q     ({HUB_DW{1'b0}}),
    .wb    (wr_wb),
    .d_rep (wr_d),
    .rd    (unused_wr_rd)
  );

  hub_lane_align u_rd_align (
    .sz    (sz_p2),
    .lo    (lo_p2),
    .d     ({HUB_DW{1'b0}}),
    .q     (mem_q),
    .wb    (unused_rd_wb),
    .d_rep (unused_rd_d),
    .rd    (rd_al)
  );

  // Slot rotation and per-cog busy flags.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      slot    <= '0;
      pending <= '0;
    end else begin
      if (ena_bus) begin
        slot <= (slot == SW'(COGS-1)) ? '0 : slot + SW'(1);
      end
      // A cog stays busy from its issue until its ack pulse is over, so a
      // request still held during ack cannot be taken twice.
      for (int i = 0; i < COGS; i++) begin
        if (ack[i]) begin
          pending[i] <= 1'b0;
        end else if (issue && (slot == SW'(i))) begin
          pending[i] <= 1'b1;
        end
      end
    end
  end

  // ---- stage p1: request taken, memory command driven for one cycle ----
  // Memory command register; mem_ena qualifies the other mem_* outputs.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      mem_ena <= 1'b0;
      mem_w   <= 1'b0;
      mem_wb  <= 4'b0000;
      mem_a   <= '0;
      mem_d   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      mem_ena <= issue;
      vld_p1  <= issue;
      if (issue) begin
        mem_w  <= wr_eff;
        mem_wb <= wr_eff ? wr_wb : 4'b0000;
        mem_a  <= sel_adr[15:2];
        mem_d  <= wr_d;
      end
    end
  end

  // Owner and alignment info ride alongside the valid bits; vld_pN qualifies them.
  always_ff @(posedge clk_cog) begin
    if (issue) begin
      owner_p1 <= slot;
      sz_p1    <= sel_sz;
      lo_p1    <= sel_adr[1:0];
    end
    owner_p2 <= owner_p1;
    sz_p2    <= sz_p1;
    lo_p2    <= lo_p1;
  end

  // ---- stage p2: memory has sampled, mem_q valid during this cycle ----
  // Valid for the stage where memory read data is on mem_q.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
  end

  // One-hot ack toward the cog that owns the access in stage p2.
  always_comb begin
    ack_nxt = '0;
    for (int i = 0; i < COGS; i++) begin
      if (vld_p2 && (owner_p2 == SW'(i))) begin
        ack_nxt[i] = 1'b1;
      end
    end
  end

  // ---- response: aligned data and ack registered together ----
  // rd_q keeps its last value between acks.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      ack  <= '0;
      rd_q <= '0;
    end else begin
      ack <= ack_nxt;
      if (vld_p2) begin
        rd_q <= rd_al;
      end
    end
  end

endmodule

// File: tb/tb_hub_mem_initiator.sv
// Directed bench for hub_mem_initiator with a behavioural read-before-write
// hub memory. Expectations follow HUB_ROM_WP_EN when it is defined.
module tb_hub_mem_initiator;

  localparam int COGS = 8;
  localparam int SW   = 4;

  logic                clk;
  logic                res;
  logic                ena_bus;
  logic [COGS-1:0]     req;
  logic [COGS-1:0]     req_w;
  logic [2*COGS-1:0]   req_sz;
  logic [16*COGS-1:0]  req_adr;
  logic [32*COGS-1:0]  req_d;
  logic [COGS-1:0]     ack;
  logic [31:0]         rd_q;
  logic [SW-1:0]       slot;
  logic                mem_ena;
  logic                mem_w;
  logic [3:0]          mem_wb;
  logic [13:0]         mem_a;
  logic [31:0]         mem_d;
  logic [31:0]         mem_q;

  logic [31:0]         mem [0:16383];

  int n_chk;
  int n_fail;

  // Results of the most recent single access.
  logic                r_ok;
  logic [31:0]         r_q;
  logic [13:0]         r_a;
  logic [3:0]          r_wb;
  logic [31:0]         r_md;
  logic                r_mw;
  logic                r_ena2;
  logic [COGS-1:0]     r_ack;
  int                  r_lat;

  hub_mem_initiator #(.COGS(COGS), .SW(SW)) dut (
    .clk_cog (clk),
    .res     (res),
    .ena_bus (ena_bus),
    .req     (req),
    .req_w   (req_w),
    .req_sz  (req_sz),
    .req_adr (req_adr),
    .req_d   (req_d),
    .ack     (ack),
    .rd_q    (rd_q),
    .slot    (slot),
    .mem_ena (mem_ena),
    .mem_w   (mem_w),
    .mem_wb  (mem_wb),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_q   (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hub memory: samples on the edge after mem_ena, returns old contents.
  always @(posedge clk) begin : mem_model
    logic [31:0] nw;
    if (mem_ena) begin
      mem_q <= mem[mem_a];
      nw = mem[mem_a];
      for (int b = 0; b < 4; b++) begin
        if (mem_w && mem_wb[b]) nw[8*b +: 8] = mem_d[8*b +: 8];
      end
      mem[mem_a] <= nw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one access for one cog with everyone else idle; record what happened.
  task automatic run_access(input int cog, input logic w, input logic [1:0] sz,
                            input logic [15:0] adr, input logic [31:0] d);
    int t_iss;
    t_iss  = -1;
    r_ok   = 1'b0;
    r_q    = '0;
    r_a    = '0;
    r_wb   = '0;
    r_md   = '0;
    r_mw   = 1'b0;
    r_ena2 = 1'b1;
    r_ack  = '0;
    r_lat  = -1;
    req_w[cog]            = w;
    req_sz[2*cog +: 2]    = sz;
    req_adr[16*cog +: 16] = adr;
    req_d[32*cog +: 32]   = d;
    req[cog]              = 1'b1;
    for (int n = 0; n < 40 && !r_ok; n++) begin
      tick();
      if (t_iss >= 0 && n == t_iss + 1) r_ena2 = mem_ena;
      if (mem_ena && t_iss < 0) begin
        t_iss = n;
        r_a   = mem_a;
        r_wb  = mem_wb;
        r_md  = mem_d;
        r_mw  = mem_w;
      end
      if (ack != '0) begin
        r_ok     = 1'b1;
        r_ack    = ack;
        r_q      = rd_q;
        r_lat    = n - t_iss;
        req[cog] = 1'b0;
      end
    end
    req[cog] = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; ena_bus = 1'b0;
    req = '0; req_w = '0; req_sz = '0; req_adr = '0; req_d = '0;
    tick(); tick();
    n_chk++;
    if ({ack, rd_q, slot, mem_ena, mem_w, mem_wb, mem_a, mem_d} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%h rd_q=%h slot=%h ena=%b w=%b wb=%h a=%h d=%h, all required 0",
               ack, rd_q, slot, mem_ena, mem_w, mem_wb, mem_a, mem_d);
    end
    res = 1'b0;
    tick();
    n_chk++;
    if ({ack, slot, mem_ena} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: ack=%h slot=%h ena=%b, required 0", ack, slot, mem_ena);
    end
  endtask

  task automatic test_slot();
    ena_bus = 1'b0;
    tick(); tick(); tick();
    n_chk++;
    if (slot !== 4'd0) begin
      n_fail++;
      $display("FAIL slot_hold: slot=%0d required 0", slot);
    end
    ena_bus = 1'b1;
    tick();
    n_chk++;
    if (slot !== 4'd1) begin
      n_fail++;
      $display("FAIL slot_step: slot=%0d required 1", slot);
    end
    for (int i = 0; i < 6; i++) tick();
    n_chk++;
    if (slot !== 4'd7) begin
      n_fail++;
      $display("FAIL slot_top: slot=%0d required 7", slot);
    end
    tick();
    n_chk++;
    if (slot !== 4'd0) begin
      n_fail++;
      $display("FAIL slot_wrap: slot=%0d required 0", slot);
    end
  endtask

  task automatic test_long();
    ena_bus = 1'b1;
    run_access(3, 1'b1, 2'b10, 16'h0010, 32'h12345678);
    n_chk++;
    if (r_ok !== 1'b1) begin n_fail++; $display("FAIL long_wr_ack: no ack within budget"); end
    n_chk++;
    if (r_a !== 14'h0004) begin n_fail++; $display("FAIL long_wr_a: a=%h required 0004", r_a); end
    n_chk++;
    if (r_wb !== 4'b1111 || r_mw !== 1'b1) begin
      n_fail++; $display("FAIL long_wr_wb: wb=%b w=%b required 1111/1", r_wb, r_mw);
    end
    n_chk++;
    if (r_md !== 32'h12345678) begin n_fail++; $display("FAIL long_wr_d: d=%h required 12345678", r_md); end
    n_chk++;
    if (r_ena2 !== 1'b0) begin n_fail++; $display("FAIL long_ena_pulse: ena still %b one cycle later, required 0", r_ena2); end
    // Sampling edge T0, then two more edges before ack is visible.
    n_chk++;
    if (r_lat != 2) begin n_fail++; $display("FAIL long_latency: %0d edges after issue, required 2", r_lat); end
    n_chk++;
    if (r_ack !== 8'b0000_1000) begin n_fail++; $display("FAIL long_ack_owner: ack=%b required 00001000", r_ack); end
    n_chk++;
    if (r_q !== 32'h00000000) begin n_fail++; $display("FAIL long_wr_prev: rd_q=%h required 00000000", r_q); end
    tick();
    n_chk++;
    if (ack !== '0) begin n_fail++; $display("FAIL long_ack_width: ack=%b required 0", ack); end
    run_access(3, 1'b0, 2'b10, 16'h0010, 32'h0);
    n_chk++;
    if (r_mw !== 1'b0) begin n_fail++; $display("FAIL long_rd_w: w=%b required 0", r_mw); end
    n_chk++;
    if (r_q !== 32'h12345678) begin n_fail++; $display("FAIL long_rd: rd_q=%h required 12345678", r_q); end
    tick();
  endtask

  task automatic test_byte();
    run_access(3, 1'b1, 2'b00, 16'h0013, 32'h000000AB);
    n_chk++;
    if (r_wb !== 4'b1000) begin n_fail++; $display("FAIL byte_wr_wb: wb=%b required 1000", r_wb); end
    n_chk++;
    if (r_md !== 32'hABABABAB) begin n_fail++; $display("FAIL byte_wr_d: d=%h required ABABABAB", r_md); end
    n_chk++;
    if (r_q !== 32'h00000012) begin n_fail++; $display("FAIL byte_wr_prev: rd_q=%h required 00000012", r_q); end
    tick();
    run_access(3, 1'b0, 2'b00, 16'h0013, 32'h0);
    n_chk++;
    if (r_q !== 32'h000000AB) begin n_fail++; $display("FAIL byte_rd3: rd_q=%h required 000000AB", r_q); end
    tick();
    run_access(6, 1'b0, 2'b00, 16'h0010, 32'h0);
    n_chk++;
    if (r_q !== 32'h00000078 || r_ack !== 8'b0100_0000) begin
      n_fail++; $display("FAIL byte_rd0: rd_q=%h ack=%b required 00000078/01000000", r_q, r_ack);
    end
    tick();
  endtask

  task automatic test_word();
    run_access(5, 1'b1, 2'b10, 16'h0010, 32'hABCD5678);
    tick();
    run_access(5, 1'b0, 2'b01, 16'h0012, 32'h0);
    n_chk++;
    if (r_q !== 32'h0000ABCD) begin n_fail++; $display("FAIL word_rd_hi: rd_q=%h required 0000ABCD", r_q); end
    tick();
    run_access(5, 1'b0, 2'b01, 16'h0011, 32'h0);
    n_chk++;
    if (r_q !== 32'h00005678) begin n_fail++; $display("FAIL word_rd_odd: rd_q=%h required 00005678", r_q); end
    tick();
    run_access(0, 1'b1, 2'b01, 16'h0016, 32'h1234BEEF);
    n_chk++;
    if (r_wb !== 4'b1100 || r_md !== 32'hBEEFBEEF || r_a !== 14'h0005) begin
      n_fail++; $display("FAIL word_wr: wb=%b d=%h a=%h required 1100/BEEFBEEF/0005", r_wb, r_md, r_a);
    end
    tick();
    run_access(0, 1'b0, 2'b10, 16'h0014, 32'h0);
    n_chk++;
    if (r_q !== 32'hBEEF0000) begin n_fail++; $display("FAIL word_wr_rb: rd_q=%h required BEEF0000", r_q); end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_cog;
    exp_cog = 0;
    res = 1'b1;
    #2;
    res = 1'b0;
    for (int i = 0; i < COGS; i++) begin
      req_w[i]            = 1'b0;
      req_sz[2*i +: 2]    = 2'b10;
      req_adr[16*i +: 16] = 16'h0100 + 16'(4*i);
    end
    req     = '1;
    ena_bus = 1'b1;
    // ena_bus is high on odd edges: cog k issues at edge 2k+1, acks at 2k+3.
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (ack != '0) begin
        n_chk++;
        if (exp_cog >= COGS || ack !== 8'(1 << exp_cog) || n != 2*exp_cog + 3 ||
            rd_q !== (32'hC0DE0000 + 32'(exp_cog))) begin
          n_fail++;
          $display("FAIL rr_ack%0d: ack=%b at edge %0d rd_q=%h, required %b at edge %0d rd_q=%h",
                   exp_cog, ack, n, rd_q, 8'(1 << exp_cog), 2*exp_cog + 3, 32'hC0DE0000 + 32'(exp_cog));
        end
        req = req & ~ack;
        exp_cog++;
      end
      ena_bus = ~ena_bus;
    end
    n_chk++;
    if (exp_cog != COGS) begin n_fail++; $display("FAIL rr_count: %0d acks required %0d", exp_cog, COGS); end
    req     = '0;
    ena_bus = 1'b1;
    tick();
  endtask

  task automatic test_reset_midflight();
    logic found;
    logic got;
    logic stale;
    int   n_ena;
    int   t_iss;
    found = 1'b0;
    ena_bus = 1'b1;
    req_w[2]          = 1'b0;
    req_sz[4 +: 2]    = 2'b10;
    req_adr[32 +: 16] = 16'h0108;
    req[2]            = 1'b1;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (mem_ena) found = 1'b1;
    end
    n_chk++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL mid_issue: no issue within budget"); end
    #1;
    res = 1'b1;
    #1;
    n_chk++;
    if (mem_ena !== 1'b0 || slot !== 4'd0 || ack !== '0) begin
      n_fail++; $display("FAIL mid_reset: ena=%b slot=%0d ack=%b required 0/0/0", mem_ena, slot, ack);
    end
    #1;
    res = 1'b0;
    got = 1'b0; stale = 1'b0; n_ena = 0; t_iss = -1;
    for (int n = 0; n < 30 && !got; n++) begin
      tick();
      if (mem_ena) begin n_ena++; t_iss = n; end
      if (ack != '0) begin
        got = 1'b1;
        if (n_ena == 0) stale = 1'b1;
        r_lat  = n - t_iss;
        r_q    = rd_q;
        r_ack  = ack;
        req[2] = 1'b0;
      end
    end
    req[2] = 1'b0;
    n_chk++;
    if (got !== 1'b1 || stale !== 1'b0 || n_ena != 1) begin
      n_fail++; $display("FAIL mid_reissue: got=%b stale=%b issues=%0d required 1/0/1", got, stale, n_ena);
    end
    n_chk++;
    if (r_lat != 2 || r_ack !== 8'b0000_0100 || r_q !== 32'hC0DE0002) begin
      n_fail++; $display("FAIL mid_result: lat=%0d ack=%b rd_q=%h required 2/00000100/C0DE0002", r_lat, r_ack, r_q);
    end
    tick();
  endtask

  task automatic test_rom();
    run_access(1, 1'b1, 2'b10, 16'h8000, 32'h11111111);
    n_chk++;
    if (r_a !== 14'h2000) begin n_fail++; $display("FAIL rom_a: a=%h required 2000", r_a); end
`ifdef HUB_ROM_WP_EN
    n_chk++;
    if (r_mw !== 1'b0 || r_wb !== 4'b0000) begin
      n_fail++; $display("FAIL rom_protect: w=%b wb=%b required 0/0000", r_mw, r_wb);
    end
`else
    n_chk++;
    if (r_mw !== 1'b1 || r_wb !== 4'b1111) begin
      n_fail++; $display("FAIL rom_pass: w=%b wb=%b required 1/1111", r_mw, r_wb);
    end
`endif
    n_chk++;
    if (r_ok !== 1'b1 || r_q !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rom_rd_q: ok=%b rd_q=%h required 1/DEADBEEF", r_ok, r_q);
    end
    tick();
    run_access(1, 1'b0, 2'b10, 16'h8000, 32'h0);
    n_chk++;
`ifdef HUB_ROM_WP_EN
    if (r_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rom_after: rd_q=%h required DEADBEEF", r_q); end
`else
    if (r_q !== 32'h11111111) begin n_fail++; $display("FAIL rom_after: rd_q=%h required 11111111", r_q); end
`endif
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    for (int i = 0; i < COGS; i++) mem[14'h0040 + 14'(i)] = 32'hC0DE0000 + 32'(i);
    mem[14'h2000] = 32'hDEADBEEF;

    test_reset();
    test_slot();
    test_long();
    test_byte();
    test_word();
    test_round_robin();
    test_reset_midflight();
    test_rom();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
